param_2to1_stream_arbiter: RTL and testbench

- Shares one parameterised 2-to-1 datapath mux between two valid/ready requester streams and drives a single registered output stream.
- Round-robin arbitration between requesters, plus burst locking: a multi-beat message from one requester is never interleaved with the other's.
- Sits in front of any shared nbits-wide sink, such as a memory port or network injection point, and owns the mux select.

---
 rtl/param_2to1_stream_arbiter.sv | 130 +++++++++++++
 tb/tb_param_2to1_stream_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_2to1_stream_arbiter.sv
// Purpose: round-robin 2-to-1 valid/ready stream arbiter with burst locking and a
//          single registered output stage; a locked burst is never interleaved.
// Latency: one cycle from an accepted input beat to out_*.
// Backpressure: in*_rdy is combinational from out_rdy; the output stage refills in
//          the same cycle it drains, and holds out_* stable while out_val && !out_rdy.
// Ports:
//   clk, reset            clock (rising edge) and asynchronous active-low reset
//   in0_val/rdy/msg/last  requester 0 stream
//   in1_val/rdy/msg/last  requester 1 stream
//   out_val/rdy/msg/last  registered output stream
//   out_src               requester index that produced the current output beat
module param_2to1_stream_arbiter #(
   parameter int nbits = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_val,
   output logic             in0_rdy,
   input  logic [nbits-1:0] in0_msg,
   input  logic             in0_last,
   input  logic             in1_val,
   output logic             in1_rdy,
   input  logic [nbits-1:0] in1_msg,
   input  logic             in1_last,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [nbits-1:0] out_msg,
   output logic             out_last,
   output logic             out_src
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   prio, prio_nxt;

   logic             enq_ok;
   logic             grant_vld;
   logic             grant_idx;
   logic             xfer;
   logic [nbits-1:0] sel_msg;
   logic             sel_last;

   // Output register may be overwritten when empty or when it drains this cycle.
   assign enq_ok = !out_val || out_rdy;

   // Grant: an open burst owns the mux outright; otherwise round-robin on ties.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 1'b0;
      case (state)
         IDLE: begin
            if (in0_val && in1_val) begin
               grant_vld = 1'b1;
               grant_idx = prio;
            end else if (in0_val) begin
               grant_vld = 1'b1;
               grant_idx = 1'b0;
            end else if (in1_val) begin
               grant_vld = 1'b1;
               grant_idx = 1'b1;
            end
         end
         LOCK0: begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
         end
         LOCK1: begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
         end
         default: begin
            grant_vld = 1'b0;
            grant_idx = 1'b0;
         end
      endcase
   end

   assign in0_rdy = reset && enq_ok && grant_vld && (grant_idx == 1'b0);
   assign in1_rdy = reset && enq_ok && grant_vld && (grant_idx == 1'b1);

   assign xfer     = (in0_val && in0_rdy) || (in1_val && in1_rdy);
   assign sel_msg  = grant_idx ? in1_msg  : in0_msg;
   assign sel_last = grant_idx ? in1_last : in0_last;

   // Next state: the last beat closes the burst and hands priority to the other side.
   always_comb begin
      state_nxt = state;
      prio_nxt  = prio;
      if (xfer) begin
         if (sel_last) begin
            state_nxt = IDLE;
            prio_nxt  = !grant_idx;
         end else begin
            state_nxt = grant_idx ? LOCK1 : LOCK0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         prio  <= 1'b0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_val  <= 1'b0;
         out_msg  <= '0;
         out_last <= 1'b0;
         out_src  <= 1'b0;
      end else if (enq_ok) begin
         out_val <= xfer;
         if (xfer) begin
            out_msg  <= sel_msg;
            out_last <= sel_last;
            out_src  <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_param_2to1_stream_arbiter.sv
module tb_param_2to1_stream_arbiter;

   localparam int NB = 8;

   logic          clk;
   logic          reset;
   logic          in0_val, in0_rdy, in0_last;
   logic [NB-1:0] in0_msg;
   logic          in1_val, in1_rdy, in1_last;
   logic [NB-1:0] in1_msg;
   logic          out_val, out_rdy, out_last, out_src;
   logic [NB-1:0] out_msg;

   int checks;
   int failures;

   param_2to1_stream_arbiter #(.nbits(NB)) dut (
      .clk      (clk),
      .reset    (reset),
      .in0_val  (in0_val),
      .in0_rdy  (in0_rdy),
      .in0_msg  (in0_msg),
      .in0_last (in0_last),
      .in1_val  (in1_val),
      .in1_rdy  (in1_rdy),
      .in1_msg  (in1_msg),
      .in1_last (in1_last),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_msg  (out_msg),
      .out_last (out_last),
      .out_src  (out_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // owner: -1 when no burst is open, else the requester holding the lock.
   int            m_owner;
   logic          m_prio;
   logic          m_val;
   logic [NB-1:0] m_msg;
   logic          m_last;
   logic          m_src;

   function automatic int who_wins();
      if (m_owner >= 0)       return m_owner;
      if (in0_val && in1_val) return int'(m_prio);
      if (in0_val)            return 0;
      if (in1_val)            return 1;
      return -1;
   endfunction

   function automatic logic exp_rdy(input int i);
      return reset && (!m_val || out_rdy) && (who_wins() == i);
   endfunction

   always @(posedge clk or negedge reset) begin
      int  g;
      logic took;
      if (!reset) begin
         m_owner = -1;
         m_prio  = 1'b0;
         m_val   = 1'b0;
         m_msg   = '0;
         m_last  = 1'b0;
         m_src   = 1'b0;
      end else begin
         g    = who_wins();
         took = exp_rdy(0) && in0_val || exp_rdy(1) && in1_val;
         if (!m_val || out_rdy) m_val = took;
         if (took) begin
            m_msg  = (g == 1) ? in1_msg  : in0_msg;
            m_last = (g == 1) ? in1_last : in0_last;
            m_src  = (g == 1);
            if (m_last) begin
               m_owner = -1;
               m_prio  = (g == 0);
            end else begin
               m_owner = g;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   logic run_cmp;
   initial run_cmp = 1'b0;
   always @(negedge clk) begin
      if (run_cmp) begin
         chk("m_in0_rdy", in0_rdy, exp_rdy(0));
         chk("m_in1_rdy", in1_rdy, exp_rdy(1));
         chk("m_out_val", out_val, m_val);
         if (m_val) begin
            chk("m_out_msg",  out_msg,  m_msg);
            chk("m_out_last", out_last, m_last);
            chk("m_out_src",  out_src,  m_src);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic drive0(input logic v, input logic [NB-1:0] m, input logic l);
      in0_val = v; in0_msg = m; in0_last = l;
   endtask

   task automatic drive1(input logic v, input logic [NB-1:0] m, input logic l);
      in1_val = v; in1_msg = m; in1_last = l;
   endtask

   logic [NB-1:0] seq [4];

   initial begin
      checks   = 0;
      failures = 0;
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h11; seq[3] = 8'h22;
      reset   = 1'b0;
      out_rdy = 1'b1;
      drive0(1'b1, 8'h11, 1'b1);
      drive1(1'b1, 8'h22, 1'b1);
      run_cmp = 1'b1;

      // Reset held two cycles with both requesters valid.
      samp(); samp();
      chk("rst_out_val", out_val, 0);
      chk("rst_out_msg", out_msg, 0);
      chk("rst_in0_rdy", in0_rdy, 0);
      chk("rst_in1_rdy", in1_rdy, 0);
      tick(); reset = 1'b1;
      samp();
      chk("rel_in0_rdy", in0_rdy, 1);
      chk("rel_in1_rdy", in1_rdy, 0);

      // Single-beat alternation.
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 3) begin
            in0_val = 1'b0;
            in1_val = 1'b0;
         end
         samp();
         chk("alt_val", out_val, 1);
         chk("alt_msg", out_msg, seq[k]);
         chk("alt_src", out_src, k % 2);
      end

      // Burst lock: A0,A1,A2 from requester 0 while requester 1 waits with B0.
      tick(); drive0(1'b1, 8'hA0, 1'b0); drive1(1'b1, 8'hB0, 1'b1);
      samp(); chk("bl_idle_val", out_val, 0); chk("bl_in0_rdy", in0_rdy, 1); chk("bl_in1_rdy0", in1_rdy, 0);
      tick(); drive0(1'b1, 8'hA1, 1'b0);
      samp(); chk("bl_msg0", out_msg, 8'hA0); chk("bl_in1_rdy1", in1_rdy, 0);
      tick(); drive0(1'b1, 8'hA2, 1'b1);
      samp(); chk("bl_msg1", out_msg, 8'hA1); chk("bl_in1_rdy2", in1_rdy, 0);
      tick(); in0_val = 1'b0;
      samp(); chk("bl_msg2", out_msg, 8'hA2); chk("bl_last2", out_last, 1); chk("bl_in1_rdy3", in1_rdy, 1);
      tick(); in1_val = 1'b0;
      samp(); chk("bl_msgB", out_msg, 8'hB0); chk("bl_srcB", out_src, 1);

      // Backpressure with a full buffer.
      tick(); drive0(1'b1, 8'h5C, 1'b1); drive1(1'b1, 8'h77, 1'b1);
      samp(); chk("bp_in0_rdy", in0_rdy, 1);
      tick(); out_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         samp();
         chk("bp_hold_msg", out_msg, 8'h5C);
         chk("bp_hold_val", out_val, 1);
         chk("bp_in0_rdy0", in0_rdy, 0);
         chk("bp_in1_rdy0", in1_rdy, 0);
         if (k < 2) tick();
      end
      tick(); out_rdy = 1'b1;
      samp(); chk("bp_still_msg", out_msg, 8'h5C); chk("bp_in1_rdy", in1_rdy, 1);
      tick(); in0_val = 1'b0; in1_val = 1'b0;
      samp(); chk("bp_nobubble_val", out_val, 1); chk("bp_next_msg", out_msg, 8'h77); chk("bp_next_src", out_src, 1);
      tick();
      samp(); chk("bp_drained", out_val, 0);

      // Lock gap: requester 1 pauses mid-burst; requester 0 stays blocked.
      tick(); drive1(1'b1, 8'h01, 1'b0);
      samp(); chk("lg_in1_rdy", in1_rdy, 1);
      tick(); in1_val = 1'b0; drive0(1'b1, 8'h33, 1'b1);
      samp(); chk("lg_in0_blk0", in0_rdy, 0); chk("lg_msg01", out_msg, 8'h01);
      tick();
      samp(); chk("lg_in0_blk1", in0_rdy, 0);
      tick(); drive1(1'b1, 8'h02, 1'b1);
      samp(); chk("lg_in1_rdy2", in1_rdy, 1); chk("lg_in0_blk2", in0_rdy, 0);
      tick(); in1_val = 1'b0;
      samp(); chk("lg_msg02", out_msg, 8'h02); chk("lg_in0_grant", in0_rdy, 1);
      tick(); in0_val = 1'b0;
      samp(); chk("lg_msg33", out_msg, 8'h33); chk("lg_src33", out_src, 0);

      // Reset mid-burst in LOCK1 with a full buffer.
      tick(); drive1(1'b1, 8'hC1, 1'b0);
      samp(); chk("rm_in1_rdy", in1_rdy, 1);
      tick(); drive1(1'b1, 8'hC2, 1'b0); drive0(1'b1, 8'hD0, 1'b1);
      samp(); chk("rm_val", out_val, 1); chk("rm_msg", out_msg, 8'hC1); chk("rm_in0_blk", in0_rdy, 0);
      #1 reset = 1'b0;
      #1;
      chk("rm_async_val", out_val, 0);
      chk("rm_async_msg", out_msg, 0);
      chk("rm_async_rdy0", in0_rdy, 0);
      chk("rm_async_rdy1", in1_rdy, 0);
      #1 reset = 1'b1;
      #1;
      chk("rm_rel_in0", in0_rdy, 1);
      chk("rm_rel_in1", in1_rdy, 0);
      tick(); in0_val = 1'b0;
      samp(); chk("rm_msgD0", out_msg, 8'hD0); chk("rm_srcD0", out_src, 0);
      tick(); in1_val = 1'b0;
      samp();
      run_cmp = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
